// File: rtl/ysyx_22050243_pkg.sv
// Shared types and constants for the writeback unit.
// Optional difftest commit ports: define YSYX_22050243_DIFFTEST_EN.
package ysyx_22050243_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned GPR_AW  = 5;
  localparam int unsigned PC_W    = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wbu_state_e;

  // RISC-V load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/ysyx_22050243_load_ext.sv
// Load data alignment and sign/zero extension (purely combinational).
// Raw doubleword is shifted right by the byte offset (zero fill), then
// the low byte/half/word is extended according to funct3.
module ysyx_22050243_load_ext
  import ysyx_22050243_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic [2:0]            funct3_i,
  input  logic [2:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ext_o
);

  logic [DATA_WIDTH-1:0] shifted;

  // Align the addressed byte to bit 0, then extend by access size
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    ext_o   = shifted;
    unique case (funct3_i)
      LB:      ext_o = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      LH:      ext_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      LW:      ext_o = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      LBU:     ext_o = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
      LHU:     ext_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      LWU:     ext_o = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: ext_o = shifted;  // LD and the unused 3'b111 encoding
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_wbu.sv
// Writeback unit: sole driver of the GPR write port.
// Accepts EXU results, waits for load data when needed, and issues one
// GPR write per committed instruction (writes to x0 suppressed).
// Optional difftest commit ports: define YSYX_22050243_DIFFTEST_EN.
module ysyx_22050243_wbu
  import ysyx_22050243_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = XLEN,
  parameter int unsigned REG_ADDR_WIDTH = GPR_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic                      in_is_load,
  input  logic [2:0]                in_ld_funct3,
  input  logic [2:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
`ifdef YSYX_22050243_DIFFTEST_EN
  input  logic [PC_W-1:0]           in_pc,
  output logic                      commit,
  output logic [PC_W-1:0]           commit_pc,
`endif
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      w_en,
  output logic [REG_ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0]     w_data
);

  wbu_state_e state_q, state_d;

  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      rd_wen_q;
  logic                      is_load_q;
  logic [2:0]                funct3_q;
  logic [2:0]                addr_lo_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0]     ld_ext;
  logic                      hs;

`ifdef YSYX_22050243_DIFFTEST_EN
  logic [PC_W-1:0] pc_q;
  logic            commit_q;
  logic [PC_W-1:0] commit_pc_q, commit_pc_d;
`endif

  assign hs = in_valid && in_ready;

  ysyx_22050243_load_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_ext (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (mem_rdata),
    .ext_o     (ld_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, COMMIT: begin
        if (hs) state_d = in_is_load ? WAIT_MEM : COMMIT;
        else    state_d = IDLE;
      end
      WAIT_MEM: if (mem_rvalid && is_load_q) state_d = COMMIT;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake readiness depends on state only
  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == COMMIT);
  end

  // Write enable for the upcoming COMMIT cycle; a non-load entering COMMIT
  // uses the fields being captured this cycle, a load uses the held ones
  always_comb begin
    w_en_d = 1'b0;
    if (state_d == COMMIT) begin
      if (hs) w_en_d = in_rd_wen && (in_rd != '0);
      else    w_en_d = rd_wen_q && (rd_q != '0);
    end
  end

  // Capture instruction fields on handshake; replace data with load result
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      data_q    <= '0;
      w_en_q    <= 1'b0;
    end else begin
      w_en_q <= w_en_d;
      if (hs) begin
        rd_q      <= in_rd;
        rd_wen_q  <= in_rd_wen;
        is_load_q <= in_is_load;
        funct3_q  <= in_ld_funct3;
        addr_lo_q <= in_addr_lo;
        data_q    <= in_alu_result;
      end else if (state_q == WAIT_MEM && mem_rvalid) begin
        data_q <= ld_ext;
      end
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = rd_q;
  assign w_data = data_q;

`ifdef YSYX_22050243_DIFFTEST_EN
  // PC of the instruction entering COMMIT
  always_comb begin
    commit_pc_d = commit_pc_q;
    if (state_d == COMMIT) commit_pc_d = hs ? in_pc : pc_q;
  end

  // Difftest commit strobe and held commit PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      commit_q    <= 1'b0;
      commit_pc_q <= '0;
    end else begin
      if (hs) pc_q <= in_pc;
      commit_q    <= (state_d == COMMIT);
      commit_pc_q <= commit_pc_d;
    end
  end

  assign commit    = commit_q;
  assign commit_pc = commit_pc_q;
`endif

endmodule
